// File: rtl/clk_gen_pkg.sv
// Shared types for the multi-channel clock generator: channel states, config
// record and the config legality check.
package clk_gen_pkg;

  // Config fields are carried at a fixed width so the record is CNT_W-agnostic.
  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
  } cfg_t;

  function automatic logic cfg_ok(input cfg_t c);
    return (c.period >= CFG_W'(2)) && (c.high != '0) && (c.high < c.period);
  endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// Config handshake and per-channel clock bus of clk_gen_multi.
interface clk_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
  logic              cfg_err;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] running;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_high, en,
    input  cfg_ready, cfg_err, clk_out, running
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_high, en,
    output cfg_ready, cfg_err, clk_out, running
  );
endinterface

// File: rtl/clk_gen_ch.sv
// One clock channel: IDLE/HIGH/LOW FSM with a phase counter, active config and
// a single-entry shadow config that is only adopted at a period boundary.
module clk_gen_ch
  import clk_gen_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int RST_PERIOD = 4,
  parameter int RST_HIGH   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic wr,
  input  cfg_t wr_cfg,
  output logic pending,
  output logic clk_out,
  output logic running
);

  localparam cfg_t RST_CFG = '{period: CFG_W'(RST_PERIOD), high: CFG_W'(RST_HIGH)};

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  cfg_t             active, active_n, shadow, eff;
  logic             pending_n, clk_out_n, running_n;
  logic             hit_high, hit_period, boundary;

  always_comb begin
    hit_high   = (CFG_W'(cnt) == active.high);
    hit_period = (CFG_W'(cnt) == active.period);
    boundary   = (state == IDLE) || ((state == LOW) && hit_period);
    eff        = (pending && boundary) ? shadow : active;

    state_n   = state;
    cnt_n     = cnt;
    active_n  = boundary ? eff : active;
    clk_out_n = clk_out;
    running_n = running;
    // A write at a boundary is never the one applied there: it waits for the next.
    pending_n = wr | (pending & ~boundary);

    case (state)
      IDLE: begin
        if (en) begin
          state_n   = HIGH;
          cnt_n     = CNT_W'(1);
          clk_out_n = 1'b1;
          running_n = 1'b1;
        end
      end
      HIGH: begin
        cnt_n = cnt + 1'b1;
        if (hit_high) begin
          state_n   = LOW;
          clk_out_n = 1'b0;
        end
      end
      LOW: begin
        if (!hit_period) begin
          cnt_n = cnt + 1'b1;
        end else if (en) begin
          state_n   = HIGH;
          cnt_n     = CNT_W'(1);
          clk_out_n = 1'b1;
        end else begin
          state_n   = IDLE;
          cnt_n     = '0;
          running_n = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        cnt_n     = '0;
        clk_out_n = 1'b0;
        running_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      active  <= RST_CFG;
      shadow  <= RST_CFG;
      pending <= 1'b0;
      clk_out <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      active  <= active_n;
      pending <= pending_n;
      clk_out <= clk_out_n;
      running <= running_n;
      if (wr) shadow <= wr_cfg;
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock generator: config decode/handshake and
// NUM_CH independent clk_gen_ch channels.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int RST_PERIOD = 4,
  parameter int RST_HIGH   = 2
) (
  input  logic           clk,
  input  logic           rst,
  clk_gen_multi_if.slave bus
);

  logic [NUM_CH-1:0] pending, wr, clk_out_w, running_w;
  logic              in_range, pend_sel, fire, accept;
  cfg_t              req;

  always_comb begin
    req.period = CFG_W'(bus.cfg_period);
    req.high   = CFG_W'(bus.cfg_high);
    in_range   = (int'(bus.cfg_ch) < NUM_CH);
    // Out-of-range channels read as not pending so the request transfers and is rejected.
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.cfg_ch) == i) pend_sel = pending[i];
    end
  end

  assign bus.cfg_ready = !pend_sel;
  assign fire          = bus.cfg_valid && !pend_sel;
  assign accept        = fire && in_range && cfg_ok(req);

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = accept && (int'(bus.cfg_ch) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.cfg_err <= 1'b0;
    else     bus.cfg_err <= fire && !accept;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_ch #(
      .CNT_W     (CNT_W),
      .RST_PERIOD(RST_PERIOD),
      .RST_HIGH  (RST_HIGH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en[i]),
      .wr     (wr[i]),
      .wr_cfg (req),
      .pending(pending[i]),
      .clk_out(clk_out_w[i]),
      .running(running_w[i])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.running = running_w;

endmodule
